// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters,
// with locked multi-beat chains that carry Cout into the next beat's Cin.
module adder_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned ADDER_SEL = 2,
    localparam int unsigned IDW      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_A,
    input  logic [NREQ*WIDTH-1:0] req_B,
    input  logic [NREQ-1:0]       req_Cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_Sum,
    output logic                  rsp_Cout,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_last,
    output logic                  busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_owner;
    logic               r_carry;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_sum;
    logic               r_rsp_cout;
    logic [IDW-1:0]     r_rsp_id;
    logic               r_rsp_last;

    logic               w_slot_free;
    logic               w_gnt_vld;
    logic [IDW-1:0]     w_gnt_idx;
    logic [IDW-1:0]     w_sel;
    logic [IDW-1:0]     w_ptr_nxt;
    logic               w_accept;
    logic               w_cin;
    logic               w_last;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    assign w_slot_free = !r_rsp_valid || rsp_ready;

    // First valid requester at or after rr_ptr, wrapping mod NREQ
    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(r_rr_ptr) + k) % NREQ;
            if (!w_gnt_vld && req_valid[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_sel = (r_state == ST_LOCKED) ? r_owner : w_gnt_idx;
        w_cin = (r_state == ST_LOCKED) ? r_carry : req_Cin[w_gnt_idx];
    end

    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_last = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_sel) begin
                w_a    = req_A[i*WIDTH +: WIDTH];
                w_b    = req_B[i*WIDTH +: WIDTH];
                w_last = req_last[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = w_slot_free && w_gnt_vld;
                if (w_accept && !w_last) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                w_accept = w_slot_free && req_valid[r_owner];
                if (w_accept && w_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_sel] = 1'b1;
    end

    assign w_ptr_nxt = (32'(w_sel) == NREQ - 1) ? '0 : w_sel + IDW'(1);

    generate
        if (ADDER_SEL == 0) begin : g_rca
            always_comb begin
                logic c;
                c = w_cin;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_sum[i] = w_a[i] ^ w_b[i] ^ c;
                    c        = (w_a[i] & w_b[i]) | (c & (w_a[i] ^ w_b[i]));
                end
                w_cout = c;
            end
        end else if (ADDER_SEL == 1) begin : g_cla
            // 4-bit lookahead groups, group carries rippled between groups
            logic [WIDTH-1:0] w_g;
            logic [WIDTH-1:0] w_p;
            assign w_g = w_a & w_b;
            assign w_p = w_a ^ w_b;
            always_comb begin
                logic c_blk, cj, pr;
                int unsigned jend;
                c_blk = w_cin;
                cj    = 1'b0;
                pr    = 1'b1;
                jend  = 0;
                w_sum = '0;
                for (int unsigned j0 = 0; j0 < WIDTH; j0 += 4) begin
                    jend = (j0 + 4 < WIDTH) ? j0 + 4 : WIDTH;
                    for (int unsigned j = j0; j <= jend; j++) begin
                        cj = 1'b0;
                        pr = 1'b1;
                        for (int unsigned k = j; k > j0; k--) begin
                            cj = cj | (w_g[k-1] & pr);
                            pr = pr & w_p[k-1];
                        end
                        cj = cj | (c_blk & pr);
                        if (j < jend) w_sum[j] = w_p[j] ^ cj;
                    end
                    c_blk = cj;
                end
                w_cout = c_blk;
            end
        end else begin : g_prefix
            // Kogge-Stone prefix tree with Cin folded into bit 0 generate
            logic [WIDTH-1:0] w_p0;
            assign w_p0 = w_a ^ w_b;
            always_comb begin
                logic [WIDTH-1:0] g, p;
                g    = w_a & w_b;
                p    = w_p0;
                g[0] = g[0] | (p[0] & w_cin);
                for (int unsigned d = 1; d < WIDTH; d = d * 2) begin
                    for (int unsigned i = WIDTH - 1; i >= d; i--) begin
                        g[i] = g[i] | (p[i] & g[i-d]);
                        p[i] = p[i] & p[i-d];
                    end
                end
                w_sum[0] = w_p0[0] ^ w_cin;
                for (int unsigned i = 1; i < WIDTH; i++) w_sum[i] = w_p0[i] ^ g[i-1];
                w_cout = g[WIDTH-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // New beat overwrites the slot; otherwise the slot empties once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_carry     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_last  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum;
            r_rsp_cout  <= w_cout;
            r_rsp_id    <= w_sel;
            r_rsp_last  <= w_last;
            r_carry     <= w_cout;
            r_owner     <= w_sel;
            if (w_last) r_rr_ptr <= w_ptr_nxt;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_Sum   = r_rsp_sum;
    assign rsp_Cout  = r_rsp_cout;
    assign rsp_id    = r_rsp_id;
    assign rsp_last  = r_rsp_last;
    assign busy      = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and random bench for adder_arbiter; three instances (rca, cla,
// prefix) share stimulus and are each checked against hand-computed values.
module tb_adder_arbiter;
    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_Cin;
    logic [N*W-1:0]  req_A;
    logic [N*W-1:0]  req_B;
    logic            rsp_ready;

    logic [N-1:0]    req_ready [3];
    logic            rsp_valid [3];
    logic [W-1:0]    rsp_Sum   [3];
    logic            rsp_Cout  [3];
    logic [1:0]      rsp_id    [3];
    logic            rsp_last  [3];
    logic            busy      [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        adder_arbiter #(.WIDTH(W), .NREQ(N), .ADDER_SEL(gi)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid),
            .req_ready (req_ready[gi]),
            .req_last  (req_last),
            .req_A     (req_A),
            .req_B     (req_B),
            .req_Cin   (req_Cin),
            .rsp_valid (rsp_valid[gi]),
            .rsp_ready (rsp_ready),
            .rsp_Sum   (rsp_Sum[gi]),
            .rsp_Cout  (rsp_Cout[gi]),
            .rsp_id    (rsp_id[gi]),
            .rsp_last  (rsp_last[gi]),
            .busy      (busy[gi])
        );
    end

    // Packed view {valid, cout, id, last, busy, sum} of instance d
    function automatic logic [13:0] rsp_of(input int d);
        return {rsp_valid[d], rsp_Cout[d], rsp_id[d], rsp_last[d], busy[d], rsp_Sum[d]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_last  = '0;
        req_Cin   = '0;
        req_A     = '0;
        req_B     = '0;
        rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_of(d) !== 14'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d got=%h exp=%h", d, rsp_of(d), 14'h0);
            end
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_beat();
        req_valid  = 4'b0001;
        req_last   = 4'b0001;
        req_A[7:0] = 8'hFF;
        req_B[7:0] = 8'h01;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 4'b0001) begin
                errors++;
                $display("FAIL single_ready dut%0d got=%b exp=%b", d, req_ready[d], 4'b0001);
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_of(d) !== {1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL single_rsp dut%0d got=%h exp=%h", d, rsp_of(d),
                         {1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00});
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        logic [7:0]   exp_sum;
        do_reset();
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_A     = {8'h40, 8'h30, 8'h20, 8'h10};
        req_B     = {8'h04, 8'h03, 8'h02, 8'h01};
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            exp_sum = 8'((k % 4 + 1) * 8'h11);
            #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (req_ready[d] !== exp_rdy) begin
                    errors++;
                    $display("FAIL rr_ready%0d dut%0d got=%b exp=%b", k, d, req_ready[d], exp_rdy);
                end
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rsp_of(d) !== {1'b1, 1'b0, 2'(k % 4), 1'b1, 1'b0, exp_sum}) begin
                    errors++;
                    $display("FAIL rr_rsp%0d dut%0d got=%h exp=%h", k, d, rsp_of(d),
                             {1'b1, 1'b0, 2'(k % 4), 1'b1, 1'b0, exp_sum});
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_chained();
        logic [7:0] ba [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [7:0] bb [3] = '{8'h01, 8'h00, 8'h00};
        logic [7:0] es [3] = '{8'h00, 8'h00, 8'h01};
        logic       ec [3] = '{1'b1, 1'b1, 1'b0};
        logic [13:0] exp;
        do_reset();
        req_valid    = 4'b0110;
        req_A[23:16] = 8'h05;
        req_B[23:16] = 8'h06;
        for (int bt = 0; bt < 3; bt++) begin
            req_A[15:8] = ba[bt];
            req_B[15:8] = bb[bt];
            req_last    = {1'b0, 1'b1, (bt == 2), 1'b0};
            #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (req_ready[d] !== 4'b0010) begin
                    errors++;
                    $display("FAIL chain_ready%0d dut%0d got=%b exp=%b", bt, d, req_ready[d], 4'b0010);
                end
            end
            tick();
            exp = {1'b1, ec[bt], 2'd1, (bt == 2), (bt != 2), es[bt]};
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rsp_of(d) !== exp) begin
                    errors++;
                    $display("FAIL chain_rsp%0d dut%0d got=%h exp=%h", bt, d, rsp_of(d), exp);
                end
            end
        end
        req_valid = 4'b0100;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 4'b0100) begin
                errors++;
                $display("FAIL chain_next_ready dut%0d got=%b exp=%b", d, req_ready[d], 4'b0100);
            end
        end
        tick();
        req_valid = '0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_of(d) !== {1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 8'h0B}) begin
                errors++;
                $display("FAIL chain_next_rsp dut%0d got=%h exp=%h", d, rsp_of(d),
                         {1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 8'h0B});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [13:0] held;
        do_reset();
        held       = {1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h33};
        req_valid  = 4'b0001;
        req_last   = 4'hF;
        req_A      = {8'h00, 8'h00, 8'h44, 8'h11};
        req_B      = {8'h00, 8'h00, 8'h55, 8'h22};
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (req_ready[d] !== 4'b0000 || rsp_of(d) !== held) begin
                    errors++;
                    $display("FAIL bp_hold%0d dut%0d got=%b/%h exp=%b/%h", c, d,
                             req_ready[d], rsp_of(d), 4'b0000, held);
                end
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 4'b0010) begin
                errors++;
                $display("FAIL bp_drain_ready dut%0d got=%b exp=%b", d, req_ready[d], 4'b0010);
            end
        end
        tick();
        req_valid = '0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_of(d) !== {1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 8'h99}) begin
                errors++;
                $display("FAIL bp_drain_rsp dut%0d got=%h exp=%h", d, rsp_of(d),
                         {1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 8'h99});
            end
        end
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_of(d) !== {1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'h99}) begin
                errors++;
                $display("FAIL bp_empty dut%0d got=%h exp=%h", d, rsp_of(d),
                         {1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'h99});
            end
        end
    endtask

    task automatic test_reset_mid_chain();
        do_reset();
        req_valid  = 4'b0001;
        req_last   = 4'b0000;
        req_A[7:0] = 8'hFF;
        req_B[7:0] = 8'h01;
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_of(d) !== {1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 8'h00}) begin
                errors++;
                $display("FAIL mid_beat1 dut%0d got=%h exp=%h", d, rsp_of(d),
                         {1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 8'h00});
            end
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_of(d) !== 14'h0) begin
                errors++;
                $display("FAIL mid_reset dut%0d got=%h exp=%h", d, rsp_of(d), 14'h0);
            end
        end
        tick();
        rst_n      = 1'b1;
        req_last   = 4'b0001;
        req_A[7:0] = 8'h01;
        req_B[7:0] = 8'h01;
        tick();
        req_valid = '0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_of(d) !== {1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h02}) begin
                errors++;
                $display("FAIL mid_fresh dut%0d got=%h exp=%h", d, rsp_of(d),
                         {1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h02});
            end
        end
    endtask

    task automatic test_random();
        int          beats;
        int          r;
        int          len;
        logic [7:0]  ra, rb;
        logic        rc, c_in, carry, lst;
        logic [8:0]  full;
        logic [13:0] exp;
        do_reset();
        beats = 0;
        carry = 1'b0;
        while (beats < 1000) begin
            r   = $urandom_range(0, N - 1);
            len = $urandom_range(1, 3);
            for (int bt = 0; bt < len; bt++) begin
                ra  = 8'($urandom);
                rb  = 8'($urandom);
                rc  = 1'($urandom);
                lst = (bt == len - 1);
                clear_inputs();
                req_valid          = 4'(1 << r);
                req_last           = lst ? 4'(1 << r) : 4'b0;
                req_Cin            = rc ? 4'(1 << r) : 4'b0;
                req_A[r*W +: W]    = ra;
                req_B[r*W +: W]    = rb;
                c_in  = (bt == 0) ? rc : carry;
                full  = 9'(ra) + 9'(rb) + 9'(c_in);
                carry = full[8];
                #1;
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (req_ready[d] !== 4'(1 << r)) begin
                        errors++;
                        $display("FAIL rand_ready%0d dut%0d got=%b exp=%b", beats, d,
                                 req_ready[d], 4'(1 << r));
                    end
                end
                tick();
                exp = {1'b1, full[8], 2'(r), lst, !lst, full[7:0]};
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (rsp_of(d) !== exp) begin
                        errors++;
                        $display("FAIL rand_rsp%0d dut%0d got=%h exp=%h", beats, d, rsp_of(d), exp);
                    end
                end
                beats++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of run");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_chained();
        test_backpressure();
        test_reset_mid_chain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one WIDTH-bit adder instance (rca, cla or prefix_adder, chosen by parameter) among NREQ requesters.
- Uses round-robin arbitration with valid/ready handshakes and a single-entry registered response.
- Supports multi-beat "chained" transactions for multi-precision adds. The granted requester stays locked, and the carry-out of each beat feeds the Cin of the next.
- Sits between client blocks and the adder datapath.

Parameters:
- WIDTH, 32, operand/sum width of the shared adder.
- NREQ, 4, number of requesters (2..16).
- ADDER_SEL, 2, adder to instantiate: 0 = rca, 1 = cla, 2 = prefix_adder.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_last  in  NREQ  per-requester flag: this beat ends the transaction.
- req_A  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_B  in  NREQ*WIDTH  operand B, same packing as req_A.
- req_Cin  in  NREQ  carry-in; used only on the first beat of a transaction.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_Sum  out  WIDTH  registered sum.
- rsp_Cout  out  1  registered carry-out.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the response.
- rsp_last  out  1  copy of req_last for the beat.
- busy  out  1  high while a chained transaction is locked.

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_Sum=0, rsp_Cout=0, rsp_id=0, rsp_last=0, busy=0. Internal state: rr_ptr=0, carry register=0, FSM=IDLE. Takes effect immediately, including mid-transaction; partial chains are discarded.
- Output slot availability: slot_free = !rsp_valid || rsp_ready.
- No request is accepted when slot_free=0. All req_ready are low, and rsp_* hold stable.
- FSM states are IDLE and LOCKED.
- IDLE arbitration: requester g is the first index with req_valid set, scanning from rr_ptr upward and wrapping mod NREQ.
  - If slot_free, req_ready[g]=1 and the beat is accepted on that edge.
  - Adder inputs: A and B from requester g, Cin = req_Cin[g].
  - On accept with req_last[g]=1: rr_ptr <= (g+1) mod NREQ; stay in IDLE.
  - On accept with req_last[g]=0: owner <= g, carry <= adder Cout; go to LOCKED; busy=1.
- LOCKED state:
  - Only the owner can be granted; req_ready for all others is 0.
  - Adder Cin = carry register; req_Cin is ignored.
  - Each accepted beat updates carry <= Cout.
  - On accept with req_last=1: rr_ptr <= (owner+1) mod NREQ; go to IDLE; busy drops the following cycle.
  - If the owner deasserts valid, the lock is held indefinitely (no timeout).
- Response timing:
  - A beat accepted at edge N gives rsp_valid=1 after edge N and holds until a cycle where rsp_ready=1.
  - rsp_Sum/rsp_Cout = A+B+Cin computed in WIDTH+1 bits; sum wraps mod 2^WIDTH and the overflow goes to rsp_Cout.
  - Throughput is one beat per cycle when rsp_ready is held high. Accept and response drain on the same edge are legal: the new data replaces the old.
- req_ready depends only on req_valid, FSM state, rr_ptr and rsp_valid/rsp_ready; it never depends on operand values.
- Single-requester fairness: after a grant, the same requester is not re-granted while any other requester is valid in IDLE.
- Starvation bound: a requester holding valid in IDLE is granted within NREQ-1 completed transactions.

Test Plan:
- Reset then single beat (WIDTH=8, NREQ=4): req 0 with A=0xFF, B=0x01, Cin=0, last=1 -> one cycle later rsp_valid=1, rsp_Sum=0x00, rsp_Cout=1, rsp_id=0, busy=0.
- Round-robin: all four requesters valid with last=1, rsp_ready=1 -> grants in order 0,1,2,3,0; rsp_id follows that sequence on consecutive cycles.
- Chained 24-bit add on WIDTH=8 (beats A=FF,FF,00; B=01,00,00; Cin=0):
  - Responses are Sum=00/Cout=1, Sum=00/Cout=1, Sum=01/Cout=0.
  - busy stays high between beats.
  - Requester 2, held valid throughout, is not granted until after the last beat.
- Backpressure: rsp_ready=0 for 3 cycles with requests pending -> req_ready all 0, rsp_* stable. With rsp_ready=1, the next grant occurs on the same edge as the drain.
- Async reset mid-chain after beat 1: rst_n=0 -> busy=0 and rsp_valid=0 immediately. A later fresh beat with Cin=0 uses Cin=0, not the stale carry.
- Random compare: 1000 random A/B/Cin/last from random requesters across ADDER_SEL=0,1,2 -> every response matches the reference model of (carry-chained) A+B+Cin.
